// File: rtl/topsort_arb_pkg.sv
// Shared types and sizes for the 8-port record round-robin arbiter.
package topsort_arb_pkg;
  localparam int NUM_PORTS  = 8;
  localparam int PORT_IDX_W = 3;

  typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_e;
  typedef logic [PORT_IDX_W-1:0] port_idx_t;
endpackage

// File: rtl/mux_8_to_1.sv
// Plain 8:1 record multiplexer.
module mux_8_to_1 #(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       i_sel,
  input  logic [WIDTH-1:0] i_data_0,
  input  logic [WIDTH-1:0] i_data_1,
  input  logic [WIDTH-1:0] i_data_2,
  input  logic [WIDTH-1:0] i_data_3,
  input  logic [WIDTH-1:0] i_data_4,
  input  logic [WIDTH-1:0] i_data_5,
  input  logic [WIDTH-1:0] i_data_6,
  input  logic [WIDTH-1:0] i_data_7,
  output logic [WIDTH-1:0] o_data
);
  always_comb begin
    case (i_sel)
      3'd0:    o_data = i_data_0;
      3'd1:    o_data = i_data_1;
      3'd2:    o_data = i_data_2;
      3'd3:    o_data = i_data_3;
      3'd4:    o_data = i_data_4;
      3'd5:    o_data = i_data_5;
      3'd6:    o_data = i_data_6;
      default: o_data = i_data_7;
    endcase
  end
endmodule

// File: rtl/rr_pick_8.sv
// Combinational round-robin pick: first set request at or after start, wrapping 7->0.
module rr_pick_8
  import topsort_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  port_idx_t            start,
  output logic                 found,
  output port_idx_t            idx
);
  logic [NUM_PORTS-1:0] rot;
  port_idx_t            off;

  // Rotate so that start lands at bit 0, priority-encode, then rotate the index back.
  always_comb begin
    rot = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      rot[i] = req[port_idx_t'(start + port_idx_t'(i))];
  end

  always_comb begin
    off = '0;
    for (int i = NUM_PORTS-1; i >= 0; i--)
      if (rot[i]) off = port_idx_t'(i);
  end

  assign found = |req;
  assign idx   = start + off;
endmodule

// File: rtl/record_rr_arbiter_8.sv
// 8:1 record stream arbiter: round-robin with burst lock, registered valid/ready output.
// Optional per-port grant counters on o_grant_cnt when TOPSORT_ARB_STATS_EN is defined.
module record_rr_arbiter_8
  import topsort_arb_pkg::*;
#(
  parameter int RECORD_DATA_WIDTH = 32,
  parameter int BURST_LEN         = 4,
  parameter int STAT_CNT_WIDTH    = 32
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_PORTS-1:0]         i_valid,
  input  logic [RECORD_DATA_WIDTH-1:0] i_data_0,
  input  logic [RECORD_DATA_WIDTH-1:0] i_data_1,
  input  logic [RECORD_DATA_WIDTH-1:0] i_data_2,
  input  logic [RECORD_DATA_WIDTH-1:0] i_data_3,
  input  logic [RECORD_DATA_WIDTH-1:0] i_data_4,
  input  logic [RECORD_DATA_WIDTH-1:0] i_data_5,
  input  logic [RECORD_DATA_WIDTH-1:0] i_data_6,
  input  logic [RECORD_DATA_WIDTH-1:0] i_data_7,
  output logic [NUM_PORTS-1:0]         o_ready,
  output logic                         o_valid,
  output logic [RECORD_DATA_WIDTH-1:0] o_data,
  output logic [PORT_IDX_W-1:0]        o_port,
  input  logic                         i_ready
`ifdef TOPSORT_ARB_STATS_EN
  ,output logic [NUM_PORTS*STAT_CNT_WIDTH-1:0] o_grant_cnt
`endif
);
  localparam int              BC_W      = $clog2(BURST_LEN + 1);
  localparam logic [BC_W-1:0] BURST_MAX = BC_W'(BURST_LEN);

  arb_state_e      state_q, state_d;
  port_idx_t       ptr_q, ptr_d, lock_q, lock_d;
  logic [BC_W-1:0] burst_q, burst_d;

  logic                         load_en, lock_hit, pick_found, grant_vld;
  port_idx_t                    pick_start, pick_idx, grant_idx;
  logic [RECORD_DATA_WIDTH-1:0] mux_data;

  assign load_en = !o_valid || i_ready;

  // A dropped lock searches from the port after it, so the release costs no cycle.
  assign lock_hit   = (state_q == ARB_LOCK) && i_valid[lock_q];
  assign pick_start = (state_q == ARB_LOCK) ? port_idx_t'(lock_q + 3'd1) : ptr_q;
  assign grant_vld  = lock_hit || pick_found;
  assign grant_idx  = lock_hit ? lock_q : pick_idx;

  rr_pick_8 u_pick (
    .req   (i_valid),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  mux_8_to_1 #(.WIDTH(RECORD_DATA_WIDTH)) u_mux (
    .i_sel    (grant_idx),
    .i_data_0 (i_data_0),
    .i_data_1 (i_data_1),
    .i_data_2 (i_data_2),
    .i_data_3 (i_data_3),
    .i_data_4 (i_data_4),
    .i_data_5 (i_data_5),
    .i_data_6 (i_data_6),
    .i_data_7 (i_data_7),
    .o_data   (mux_data)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      lock_q  <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      burst_q <= burst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    burst_d = burst_q;
    if (load_en) begin
      if (lock_hit) begin
        if (burst_q + 1'b1 == BURST_MAX) begin
          state_d = ARB_IDLE;
          ptr_d   = lock_q + 3'd1;
          burst_d = '0;
        end else begin
          burst_d = burst_q + 1'b1;
        end
      end else if (pick_found) begin
        if (BURST_LEN > 1) begin
          state_d = ARB_LOCK;
          lock_d  = pick_idx;
          burst_d = BC_W'(1);
        end else begin
          state_d = ARB_IDLE;
          ptr_d   = pick_idx + 3'd1;
        end
      end else begin
        state_d = ARB_IDLE;
        burst_d = '0;
      end
    end
  end

  always_comb begin
    o_ready = '0;
    if (load_en && grant_vld && !i_rst)
      o_ready = {{(NUM_PORTS-1){1'b0}}, 1'b1} << grant_idx;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_port  <= '0;
    end else if (load_en) begin
      o_valid <= grant_vld;
      if (grant_vld) begin
        o_data <= mux_data;
        o_port <= grant_idx;
      end
    end
  end

`ifdef TOPSORT_ARB_STATS_EN
  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_cnt
    logic [STAT_CNT_WIDTH-1:0] cnt_q;
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
        cnt_q <= '0;
      else if (i_valid[k] && o_ready[k] && !(&cnt_q))
        cnt_q <= cnt_q + 1'b1;
    end
    assign o_grant_cnt[k*STAT_CNT_WIDTH +: STAT_CNT_WIDTH] = cnt_q;
  end
`else
  logic unused_stat;
  assign unused_stat = |STAT_CNT_WIDTH;
`endif
endmodule

// File: tb/tb_record_rr_arbiter_8.sv
// Scoreboard bench for record_rr_arbiter_8: one BURST_LEN=1 instance and one BURST_LEN=4 instance.
module tb_record_rr_arbiter_8;
  logic        clk = 1'b0;
  logic [31:0] rec [8];

  logic        rst1, rst4;
  logic [7:0]  i_valid1, i_valid4, o_ready1, o_ready4;
  logic        i_ready1, i_ready4, o_valid1, o_valid4;
  logic [31:0] o_data1, o_data4;
  logic [2:0]  o_port1, o_port4;
`ifdef TOPSORT_ARB_STATS_EN
  logic [255:0] gcnt1;
  logic [31:0]  gcnt4;
`endif

  logic [2:0] q1 [$];
  logic [2:0] q4 [$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  record_rr_arbiter_8 #(.RECORD_DATA_WIDTH(32), .BURST_LEN(1), .STAT_CNT_WIDTH(32)) u_dut1 (
    .i_clk(clk), .i_rst(rst1), .i_valid(i_valid1),
    .i_data_0(rec[0]), .i_data_1(rec[1]), .i_data_2(rec[2]), .i_data_3(rec[3]),
    .i_data_4(rec[4]), .i_data_5(rec[5]), .i_data_6(rec[6]), .i_data_7(rec[7]),
    .o_ready(o_ready1), .o_valid(o_valid1), .o_data(o_data1), .o_port(o_port1),
    .i_ready(i_ready1)
`ifdef TOPSORT_ARB_STATS_EN
    , .o_grant_cnt(gcnt1)
`endif
  );

  record_rr_arbiter_8 #(.RECORD_DATA_WIDTH(32), .BURST_LEN(4), .STAT_CNT_WIDTH(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst4), .i_valid(i_valid4),
    .i_data_0(rec[0]), .i_data_1(rec[1]), .i_data_2(rec[2]), .i_data_3(rec[3]),
    .i_data_4(rec[4]), .i_data_5(rec[5]), .i_data_6(rec[6]), .i_data_7(rec[7]),
    .o_ready(o_ready4), .o_valid(o_valid4), .o_data(o_data4), .o_port(o_port4),
    .i_ready(i_ready4)
`ifdef TOPSORT_ARB_STATS_EN
    , .o_grant_cnt(gcnt4)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitors pop an expected source port whenever an output handshake is about to happen.
  always @(negedge clk) begin
    if (!rst1) begin
      chk("ready_onehot1", 64'($onehot0(o_ready1)), 64'd1);
      if (o_valid1 && i_ready1) begin
        if (q1.size() == 0) chk("unexpected_out1", 64'(o_port1), 64'hDEAD);
        else begin
          automatic logic [2:0] e = q1.pop_front();
          chk("port1", 64'(o_port1), 64'(e));
          chk("data1", 64'(o_data1), 64'(rec[e]));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst4) begin
      chk("ready_onehot4", 64'($onehot0(o_ready4)), 64'd1);
      if (o_valid4 && i_ready4) begin
        if (q4.size() == 0) chk("unexpected_out4", 64'(o_port4), 64'hDEAD);
        else begin
          automatic logic [2:0] e = q4.pop_front();
          chk("port4", 64'(o_port4), 64'(e));
          chk("data4", 64'(o_data4), 64'(rec[e]));
        end
      end
    end
  end

  task automatic reset4();
    i_valid4 = 8'hFF;
    i_ready4 = 1'b1;
    rst4 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid4", 64'(o_valid4), 64'd0);
    chk("rst_data4",  64'(o_data4),  64'd0);
    chk("rst_port4",  64'(o_port4),  64'd0);
    chk("rst_ready4", 64'(o_ready4), 64'd0);
    i_valid4 = 8'h00;
    rst4 = 1'b0;
  endtask

  task automatic drain4();
    i_valid4 = 8'h00;
    i_ready4 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("drained_valid4", 64'(o_valid4), 64'd0);
  endtask

  initial begin
    for (int k = 0; k < 8; k++) rec[k] = 32'h1111_1111 * (k + 1) ^ 32'h0F00_0000;
    rst1 = 1'b1; rst4 = 1'b1;
    i_valid1 = 8'hFF; i_valid4 = 8'h00;
    i_ready1 = 1'b1;  i_ready4 = 1'b1;

    // Plain round robin on the BURST_LEN=1 instance.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid1", 64'(o_valid1), 64'd0);
    chk("rst_ready1", 64'(o_ready1), 64'd0);
    chk("rst_port1",  64'(o_port1),  64'd0);
    rst1 = 1'b0;
    foreach (q1[i]) ;
    for (int k = 0; k < 8; k++) q1.push_back(3'(k));
    q1.push_back(3'd0);
    repeat (9) @(posedge clk);
    #1 i_valid1 = 8'h00;
    repeat (3) @(posedge clk);
    #1 chk("drained_valid1", 64'(o_valid1), 64'd0);

    // Bursts of four alternating between ports 2 and 5.
    reset4();
    i_valid4 = 8'h24;
    begin
      logic [2:0] seq [9] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd5, 3'd5, 3'd5, 3'd5, 3'd2};
      foreach (seq[i]) q4.push_back(seq[i]);
    end
    repeat (9) @(posedge clk);
    #1;
    drain4();

    // Downstream stall with every input valid: output must hold and nothing is accepted.
    reset4();
    i_valid4 = 8'hFF;
    i_ready4 = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", 64'(o_valid4), 64'd1);
      chk("stall_port",  64'(o_port4),  64'd0);
      chk("stall_data",  64'(o_data4),  64'(rec[0]));
      chk("stall_ready", 64'(o_ready4), 64'd0);
      @(posedge clk);
    end
`ifdef TOPSORT_ARB_STATS_EN
    #1 chk("stall_cnt0", 64'(gcnt4[3:0]), 64'd1);
`else
    #1;
`endif
    begin
      logic [2:0] seq [8] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1};
      foreach (seq[i]) q4.push_back(seq[i]);
    end
    i_ready4 = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    drain4();

    // Lock on port 3 released early hands over to port 4 without a bubble.
    reset4();
    i_valid4 = 8'h18;
    begin
      logic [2:0] seq [5] = '{3'd3, 3'd3, 3'd4, 3'd4, 3'd4};
      foreach (seq[i]) q4.push_back(seq[i]);
    end
    repeat (2) @(posedge clk);
    #1 i_valid4 = 8'h10;
    repeat (3) begin
      @(negedge clk);
      chk("no_gap", 64'(o_valid4), 64'd1);
      @(posedge clk);
    end
    #1;
    drain4();

    // Reset in the middle of a port-6 burst; afterwards the search restarts at port 0.
    reset4();
    i_valid4 = 8'h40;
    q4.push_back(3'd6);
    repeat (2) @(posedge clk);
    #1 rst4 = 1'b1;
    #1;
    chk("midrst_valid", 64'(o_valid4), 64'd0);
    chk("midrst_port",  64'(o_port4),  64'd0);
    chk("midrst_ready", 64'(o_ready4), 64'd0);
    i_valid4 = 8'hFF;
    @(posedge clk);
    #1 rst4 = 1'b0;
    q4.push_back(3'd0); q4.push_back(3'd0); q4.push_back(3'd0);
    repeat (3) @(posedge clk);
    #1;
    drain4();

`ifdef TOPSORT_ARB_STATS_EN
    // 20 handshakes on port 1 saturate its 4-bit counter.
    reset4();
    i_valid4 = 8'h02;
    for (int i = 0; i < 20; i++) q4.push_back(3'd1);
    repeat (20) @(posedge clk);
    #1;
    drain4();
    for (int k = 0; k < 8; k++)
      chk($sformatf("grant_cnt%0d", k), 64'(gcnt4[k*4 +: 4]), (k == 1) ? 64'd15 : 64'd0);
`endif

    chk("q1_empty", 64'(q1.size()), 64'd0);
    chk("q4_empty", 64'(q4.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
